// File: rtl/ycc_to_rgb_stream_pkg.sv
// Shared types and conversion constants for the Y/Cb/Cr block to RGB888 pixel streamer.
// Samples are signed two's complement, level-shifted by -128.
package ycc_to_rgb_stream_pkg;

  localparam int Q       = 8;          // system-wide sample width
  localparam int PROD_W  = Q + 10;     // sign-extended product width
  localparam int SUM_W   = PROD_W + 1; // headroom for Yp +/- scaled chroma before clamping

  localparam int C_CR_R  = 359;
  localparam int C_CB_G  = 88;
  localparam int C_CR_G  = 183;
  localparam int C_CB_B  = 454;
  localparam int C_SHIFT = 8;
  localparam int C_ROUND = 128;
  localparam int C_LEVEL = 128;

  typedef logic [Q-1:0] sample_t;
  typedef sample_t [7:0][7:0] block_t;   // [row][col]

  typedef struct packed {
    block_t y;
    block_t cb;
    block_t cr;
  } ycc_triple_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pix_t;

  function automatic logic [7:0] clamp_u8(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])
      return 8'd0;
    else if (v > SUM_W'(255))
      return 8'd255;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/ycc_to_rgb_stream_px.sv
// Two-stage single-pixel Y/Cb/Cr to RGB888 converter: stage 1 forms the Q8 products,
// stage 2 adds, shifts and clamps into the output registers. A side-band tag rides along.
module ycc2rgb_px
  import ycc_to_rgb_stream_pkg::*;
#(
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             src_valid,
  input  sample_t          y,
  input  sample_t          cb,
  input  sample_t          cr,
  input  logic [TAG_W-1:0] src_tag,
  output logic             pix_valid,
  output rgb_pix_t         pix,
  output logic [TAG_W-1:0] pix_tag,
  output logic             busy
);

  localparam logic signed [PROD_W-1:0] K_CR_R  = PROD_W'(C_CR_R);
  localparam logic signed [PROD_W-1:0] K_CB_G  = PROD_W'(C_CB_G);
  localparam logic signed [PROD_W-1:0] K_CR_G  = PROD_W'(C_CR_G);
  localparam logic signed [PROD_W-1:0] K_CB_B  = PROD_W'(C_CB_B);
  localparam logic signed [PROD_W-1:0] K_ROUND = PROD_W'(C_ROUND);
  localparam logic signed [PROD_W-1:0] K_LEVEL = PROD_W'(C_LEVEL);

  logic signed [PROD_W-1:0] y_x, cb_x, cr_x;
  logic signed [PROD_W-1:0] yp_d, pr_d, pg_d, pb_d;
  logic signed [PROD_W-1:0] yp_q, pr_q, pg_q, pb_q;
  logic signed [SUM_W-1:0]  sum_r, sum_g, sum_b;
  logic                     s1_valid;
  logic [TAG_W-1:0]         s1_tag;

  // NOTE: combinational blocks use blocking '=' so later lines see earlier results in the same pass.
  always_comb begin
    y_x  = PROD_W'($signed(y));
    cb_x = PROD_W'($signed(cb));
    cr_x = PROD_W'($signed(cr));
    yp_d = y_x + K_LEVEL;
    pr_d = K_CR_R * cr_x + K_ROUND;
    pg_d = K_CB_G * cb_x + K_CR_G * cr_x + K_ROUND;
    pb_d = K_CB_B * cb_x + K_ROUND;
  end

  always_comb begin
    sum_r = SUM_W'(yp_q) + SUM_W'(pr_q >>> C_SHIFT);
    sum_g = SUM_W'(yp_q) - SUM_W'(pg_q >>> C_SHIFT);
    sum_b = SUM_W'(yp_q) + SUM_W'(pb_q >>> C_SHIFT);
  end

  // NOTE: product registers have no reset; s1_valid qualifies them, so reset would only cost routing.
  always_ff @(posedge clk) begin
    if (en) begin
      yp_q   <= yp_d;
      pr_q   <= pr_d;
      pg_q   <= pg_d;
      pb_q   <= pb_d;
      s1_tag <= src_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      pix_valid <= 1'b0;
      pix       <= '0;
      pix_tag   <= '0;
    end else if (en) begin
      s1_valid  <= src_valid;
      pix_valid <= s1_valid;
      if (s1_valid) begin
        pix.r   <= clamp_u8(sum_r);
        pix.g   <= clamp_u8(sum_g);
        pix.b   <= clamp_u8(sum_b);
        pix_tag <= s1_tag;
      end
    end
  end

  assign busy = s1_valid || pix_valid;

endmodule

// File: rtl/ycc_to_rgb_stream.sv
// Queues 8x8 Y/Cb/Cr block triples and streams them as RGB888 pixels, row-major, one per cycle.
// Define YCC_RGB_COORD_EN to add px_row/px_col/px_blk outputs that travel with each pixel.
module ycc_to_rgb_stream
  import ycc_to_rgb_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  block_t     y_in,
  input  block_t     cb_in,
  input  block_t     cr_in,
  output logic       rgb_valid,
  input  logic       rgb_ready,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       px_last,
  output logic       overflow,
  output logic       empty
`ifdef YCC_RGB_COORD_EN
  ,
  output logic [2:0]  px_row,
  output logic [2:0]  px_col,
  output logic [15:0] px_blk
`endif
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
`ifdef YCC_RGB_COORD_EN
  localparam int TAG_W = 23;   // {blk, row, col, last}
`else
  localparam int TAG_W = 1;    // {last}
`endif

  ycc_triple_t      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [2:0]       row, col;
  logic             fifo_nonempty, advance, take, pop, push, at_last, busy;
  ycc_triple_t      head;
  sample_t          y_px, cb_px, cr_px;
  logic [TAG_W-1:0] tag, pix_tag;
  rgb_pix_t         pix;

  assign fifo_nonempty = (count != '0);
  assign advance       = !rgb_valid || rgb_ready;
  assign take          = advance && fifo_nonempty;
  assign at_last       = (row == 3'd7) && (col == 3'd7);
  assign pop           = take && at_last;
  // A full FIFO still accepts when the head block retires on the same edge.
  assign push          = valid_in && ((count != FULL) || pop);

  assign head  = mem[rd_ptr];
  assign y_px  = head.y[row][col];
  assign cb_px = head.cb[row][col];
  assign cr_px = head.cr[row][col];

`ifdef YCC_RGB_COORD_EN
  logic [15:0] blk;
  assign tag = {blk, row, col, at_last};
`else
  assign tag = at_last;
`endif

  // NOTE: the block store is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{y: y_in, cb: cb_in, cr: cr_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      row      <= '0;
      col      <= '0;
      overflow <= 1'b0;
`ifdef YCC_RGB_COORD_EN
      blk      <= '0;
`endif
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (valid_in && !push)
        overflow <= 1'b1;
      if (take) begin
        col <= col + 3'd1;
        if (col == 3'd7)
          row <= row + 3'd1;
      end
`ifdef YCC_RGB_COORD_EN
      if (pop)
        blk <= blk + 16'd1;
`endif
    end
  end

  ycc2rgb_px #(
    .TAG_W(TAG_W)
  ) u_px (
    .clk      (clk),
    .rst      (rst),
    .en       (advance),
    .src_valid(fifo_nonempty),
    .y        (y_px),
    .cb       (cb_px),
    .cr       (cr_px),
    .src_tag  (tag),
    .pix_valid(rgb_valid),
    .pix      (pix),
    .pix_tag  (pix_tag),
    .busy     (busy)
  );

  assign r       = pix.r;
  assign g       = pix.g;
  assign b       = pix.b;
  assign px_last = pix_tag[0];
  assign empty   = !fifo_nonempty && !busy;

`ifdef YCC_RGB_COORD_EN
  assign px_col = pix_tag[3:1];
  assign px_row = pix_tag[6:4];
  assign px_blk = pix_tag[22:7];
`endif

endmodule

// File: tb/tb_ycc_to_rgb_stream.sv
// Randomised self-checking bench for ycc_to_rgb_stream against an integer-arithmetic pixel model.
`timescale 1ns/1ps
module tb_ycc_to_rgb_stream;
  import ycc_to_rgb_stream_pkg::*;

  localparam int DEPTH      = 4;
  localparam int PX_PER_BLK = 64;

  typedef struct {
    int r;
    int g;
    int b;
    bit last;
  } px_t;

  logic       clk = 1'b0;
  logic       rst, valid_in, rgb_ready;
  block_t     y_in, cb_in, cr_in;
  logic       rgb_valid, px_last, overflow, empty;
  logic [7:0] r, g, b;
`ifdef YCC_RGB_COORD_EN
  logic [2:0]  px_row, px_col;
  logic [15:0] px_blk;
`endif

  int   checks = 0, failures = 0;
  px_t  exp_q[$];
  int   px_count = 0, cyc = 0, first_v = -1, last_v = -1, v_count = 0;
  logic stalled = 1'b0;
  logic [7:0] hold_r, hold_g, hold_b;
  logic hold_last;

  ycc_to_rgb_stream dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .rgb_valid(rgb_valid), .rgb_ready(rgb_ready),
    .r(r), .g(g), .b(b),
    .px_last(px_last), .overflow(overflow), .empty(empty)
`ifdef YCC_RGB_COORD_EN
    , .px_row(px_row), .px_col(px_col), .px_blk(px_blk)
`endif
  );

  always #5 clk = ~clk;

  function automatic int clamp8(int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic px_t model_px(int y, int cb, int cr, bit last);
    px_t p;
    int  yp;
    yp     = y + 128;
    p.r    = clamp8(yp + ((359 * cr + 128) >>> 8));
    p.g    = clamp8(yp - ((88 * cb + 183 * cr + 128) >>> 8));
    p.b    = clamp8(yp + ((454 * cb + 128) >>> 8));
    p.last = last;
    return p;
  endfunction

  function automatic block_t fill_block(int v);
    block_t blk;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        blk[i][j] = 8'(v);
    return blk;
  endfunction

  function automatic block_t rand_block();
    block_t blk;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        blk[i][j] = 8'($urandom);
    return blk;
  endfunction

  task automatic expect_block(input block_t y, input block_t cb, input block_t cr);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        int yv, cbv, crv;
        yv  = $signed(y[i][j]);
        cbv = $signed(cb[i][j]);
        crv = $signed(cr[i][j]);
        exp_q.push_back(model_px(yv, cbv, crv, (i == 7) && (j == 7)));
      end
  endtask

  // Presents one triple for exactly one clock edge; caller sits just after a rising edge.
  task automatic send_block(input block_t y, input block_t cb, input block_t cr, input bit accept);
    y_in = y; cb_in = cb; cr_in = cr; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (accept)
      expect_block(y, cb, cr);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || empty !== 1'b1) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (exp_q.size() != 0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL %s_drain: pending=%0d empty=%b, wanted pending=0 empty=1", name, exp_q.size(), empty);
    end
  endtask

  // Scoreboard and stall-hold monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst !== 1'b0) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (rgb_valid !== 1'b1 || r !== hold_r || g !== hold_g || b !== hold_b || px_last !== hold_last) begin
          failures++;
          $display("FAIL stall_hold: got v=%b rgb=%h,%h,%h last=%b, wanted v=1 rgb=%h,%h,%h last=%b",
                   rgb_valid, r, g, b, px_last, hold_r, hold_g, hold_b, hold_last);
        end
      end
      if (rgb_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        v_count++;
      end
      if (rgb_valid === 1'b1 && rgb_ready === 1'b1) begin : handshake
        px_t e;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pixel: got rgb=%h,%h,%h with nothing expected", r, g, b);
        end else begin
          e = exp_q.pop_front();
          if (r !== e.r[7:0] || g !== e.g[7:0] || b !== e.b[7:0] || px_last !== e.last) begin
            failures++;
            $display("FAIL pixel_%0d: got rgb=%0d,%0d,%0d last=%b, wanted rgb=%0d,%0d,%0d last=%b",
                     px_count, r, g, b, px_last, e.r, e.g, e.b, e.last);
          end
        end
        px_count++;
      end
      stalled   = (rgb_valid === 1'b1) && (rgb_ready === 1'b0);
      hold_r    = r;
      hold_g    = g;
      hold_b    = b;
      hold_last = px_last;
    end
  end

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; rgb_ready = 1'b1;
    y_in = '0; cb_in = '0; cr_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({rgb_valid, r, g, b, px_last, overflow, empty} !== {1'b0, 24'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: got v=%b rgb=%h,%h,%h last=%b ovf=%b empty=%b, wanted 0 0,0,0 0 0 1",
               rgb_valid, r, g, b, px_last, overflow, empty);
    end
  endtask

  task automatic test_zero_block();
    block_t z;
    z = fill_block(0);
    rgb_ready = 1'b1;
    send_block(z, z, z, 1'b1);
    checks++;
    if (rgb_valid !== 1'b0) begin
      failures++; $display("FAIL latency_edge_n: got rgb_valid=%b, wanted 0", rgb_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rgb_valid !== 1'b0) begin
      failures++; $display("FAIL latency_edge_n1: got rgb_valid=%b, wanted 0", rgb_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rgb_valid !== 1'b1 || {r, g, b} !== {8'd128, 8'd128, 8'd128}) begin
      failures++;
      $display("FAIL latency_edge_n2: got v=%b rgb=%0d,%0d,%0d, wanted v=1 rgb=128,128,128", rgb_valid, r, g, b);
    end
    drain("zero", 200);
  endtask

  task automatic test_extremes();
    send_block(fill_block(127), fill_block(-128), fill_block(127), 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rgb_valid !== 1'b1 || {r, g, b} !== {8'd255, 8'd208, 8'd28}) begin
      failures++;
      $display("FAIL extreme_first_px: got v=%b rgb=%0d,%0d,%0d, wanted v=1 rgb=255,208,28", rgb_valid, r, g, b);
    end
    send_block(fill_block(-128), fill_block(127), fill_block(-128), 1'b1);
    send_block(rand_block(), rand_block(), rand_block(), 1'b1);
    drain("extremes", 400);
  endtask

  task automatic test_back_to_back();
    first_v = -1; last_v = -1; v_count = 0;
    rgb_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      send_block(rand_block(), rand_block(), rand_block(), 1'b1);
    drain("back_to_back", 400);
    checks++;
    if (v_count != 4 * PX_PER_BLK || (last_v - first_v + 1) != 4 * PX_PER_BLK || overflow !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back: got valid_cycles=%0d span=%0d ovf=%b, wanted 256 256 0",
               v_count, last_v - first_v + 1, overflow);
    end
  endtask

  task automatic test_random_ready();
    int base;
    base = px_count;
    fork
      begin
        repeat (600) begin
          rgb_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        rgb_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          send_block(rand_block(), rand_block(), rand_block(), 1'b1);
          repeat ($urandom_range(5, 60)) @(posedge clk);
          #1;
        end
      end
    join
    drain("random_ready", 500);
    checks++;
    if (px_count - base != 3 * PX_PER_BLK || overflow !== 1'b0) begin
      failures++;
      $display("FAIL random_ready_count: got px=%0d ovf=%b, wanted px=192 ovf=0", px_count - base, overflow);
    end
  endtask

  task automatic test_overflow();
    int base;
    base = px_count;
    rgb_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++)
      send_block(rand_block(), rand_block(), rand_block(), k < DEPTH);
    @(posedge clk); #1;
    checks++;
    if (overflow !== 1'b1 || px_count != base) begin
      failures++;
      $display("FAIL overflow_set: got ovf=%b px=%0d, wanted ovf=1 px=0", overflow, px_count - base);
    end
    rgb_ready = 1'b1;
    drain("overflow", 600);
    checks++;
    if (px_count - base != DEPTH * PX_PER_BLK || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_drain: got px=%0d ovf=%b, wanted px=%0d ovf=1",
               px_count - base, overflow, DEPTH * PX_PER_BLK);
    end
  endtask

  task automatic test_reset_mid_block();
    int base, k;
    base = px_count;
    k = 0;
    rgb_ready = 1'b1;
    send_block(rand_block(), rand_block(), rand_block(), 1'b1);
    send_block(rand_block(), rand_block(), rand_block(), 1'b1);
    while (px_count - base < PX_PER_BLK + 30 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (px_count - base != PX_PER_BLK + 30) begin
      failures++;
      $display("FAIL reset_mid_reach: got px=%0d, wanted %0d", px_count - base, PX_PER_BLK + 30);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (rgb_valid !== 1'b0 || empty !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_state: got v=%b empty=%b ovf=%b, wanted 0 1 0", rgb_valid, empty, overflow);
    end
    send_block(rand_block(), rand_block(), rand_block(), 1'b1);
    drain("post_reset", 200);
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_extremes();
    test_back_to_back();
    test_random_ready();
    test_overflow();
    test_reset_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
